// File: rtl/fpu_request_sequencer_pkg.sv
// Shared opcodes and FSM state type for the fixed-point unit issue stage.
package fpu_request_sequencer_pkg;
    localparam logic [1:0] FPU_ADD  = 2'd0;
    localparam logic [1:0] FPU_SUB  = 2'd1;
    localparam logic [1:0] FPU_MUL  = 2'd2;
    localparam logic [1:0] FPU_SQRT = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } seq_state_t;
endpackage

// File: rtl/fpu_req_fifo.sv
// Two-entry synchronous request FIFO; head is the oldest entry.
module fpu_req_fifo #(
    parameter int DW = 74
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic          pop,
    input  logic [DW-1:0] data,
    output logic          full,
    output logic          empty,
    output logic [DW-1:0] head
);
    logic [DW-1:0] mem [2];
    logic          wr_ptr;
    logic          rd_ptr;
    logic [1:0]    count;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == 2'd2);
    assign empty   = (count == 2'd0);
    assign head    = mem[rd_ptr];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) begin
                wr_ptr <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            unique case ({do_push, do_pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/fpu_request_sequencer.sv
// Issue stage for the fixed-point unit: queues requests, holds operands,
// qualifies ready with minimum-latency windows and a timeout.
module fpu_request_sequencer
    import fpu_request_sequencer_pkg::*;
#(
    parameter int WIDTH           = 32,
    parameter int TAG_W           = 4,
    parameter int MUL_MIN_CYCLES  = 7,
    parameter int SQRT_MIN_CYCLES = 24,
    parameter int TIMEOUT         = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_op,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    input  logic [TAG_W-1:0] req_tag,
    output logic [WIDTH-1:0] fpu_operand_1,
    output logic [WIDTH-1:0] fpu_operand_2,
    output logic [1:0]       fpu_operation,
    input  logic [WIDTH-1:0] fpu_result,
    input  logic             fpu_ready,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic [TAG_W-1:0] rsp_tag,
    output logic             rsp_error
);
    localparam int DW = 2 * WIDTH + 2 + TAG_W;
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] MUL_MIN  = CW'(MUL_MIN_CYCLES);
    localparam logic [CW-1:0] SQRT_MIN = CW'(SQRT_MIN_CYCLES);
    localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] TO_MAX   = CW'(TIMEOUT);

    seq_state_t       state;
    seq_state_t       state_nxt;
    logic [CW-1:0]    wcnt;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;
    logic [DW-1:0]    head;
    logic [1:0]       h_op;
    logic [WIDTH-1:0] h_a;
    logic [WIDTH-1:0] h_b;
    logic [TAG_W-1:0] h_tag;
    logic             capture;
    logic             expire;

    function automatic logic [CW-1:0] min_wait(input logic [1:0] op);
        logic [CW-1:0] m;
        m = '0;
        unique case (1'b1)
            (op == FPU_MUL):  m = MUL_MIN;
            (op == FPU_SQRT): m = SQRT_MIN;
            default:          m = '0;
        endcase
        return m;
    endfunction

    assign req_ready = !full;
    assign push      = req_valid && req_ready;
    assign pop       = (state == S_IDLE) && !empty;
    assign {h_op, h_a, h_b, h_tag} = head;

    fpu_req_fifo #(.DW(DW)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .data  ({req_op, req_a, req_b, req_tag}),
        .full  (full),
        .empty (empty),
        .head  (head)
    );

    // The held operation selects the window; a ready level seen earlier is stale.
    assign capture = (state == S_WAIT) && fpu_ready
                   && (wcnt >= min_wait(fpu_operation));
    assign expire  = (state == S_WAIT) && (wcnt == TO_LAST);
    assign rsp_valid = (state == S_RESP);

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:  if (!empty) state_nxt = S_WAIT;
            S_WAIT:  if (capture || expire) state_nxt = S_RESP;
            S_RESP:  if (rsp_ready) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wcnt          <= '0;
            fpu_operand_1 <= '0;
            fpu_operand_2 <= '0;
            fpu_operation <= FPU_ADD;
            rsp_data      <= '0;
            rsp_tag       <= '0;
            rsp_error     <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (pop) begin
                        fpu_operation <= h_op;
                        fpu_operand_1 <= h_a;
                        fpu_operand_2 <= h_b;
                        rsp_tag       <= h_tag;
                        wcnt          <= '0;
                    end
                end
                S_WAIT: begin
                    if (wcnt != TO_MAX) begin
                        wcnt <= wcnt + 1'b1;
                    end
                    if (capture || expire) begin
                        rsp_data      <= capture ? fpu_result : '0;
                        rsp_error     <= !capture;
                        fpu_operation <= FPU_ADD;
                        fpu_operand_1 <= '0;
                        fpu_operand_2 <= '0;
                    end
                end
                default: begin
                end
            endcase
        end
    end
endmodule
